// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, opcode values
// and instruction field positions.
package fetch_sequencer_pkg;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OFF_MSB = 7;
    localparam int OFF_LSB = 0;

    // Opcode values as seen by the downstream decode controller.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_JUMP = 4'h2,
        OP_LOAD = 4'h3,
        OP_BEQ  = 4'h4,
        OP_STORE = 4'h5,
        OP_WIN  = 4'h6
    } opcode_e;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-pc selection: absolute jump, taken branch with signed
// 8-bit offset relative to pc+1, or sequential pc+1, all modulo 2^ADDR_W.
module next_pc_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               jump,
    input  logic               beq,
    input  logic               zero,
    output logic [ADDR_W-1:0]  next_pc
);

    logic signed [OFF_MSB-OFF_LSB:0] offset;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] jmp_pc;

    assign offset = instr[OFF_MSB:OFF_LSB];
    assign seq_pc = pc + ADDR_W'(1);
    // Signed cast sign-extends the offset; truncation to ADDR_W gives wrap-around.
    assign br_pc  = seq_pc + ADDR_W'(offset);
    assign jmp_pc = ADDR_W'(instr);

    always_comb begin
        next_pc = seq_pc;
        if (jump) begin
            next_pc = jmp_pc;
        end else if (beq && zero) begin
            next_pc = br_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Two-state instruction fetch sequencer: requests a word, holds it for
// execution, then advances pc and register window on completion.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               jump,
    input  logic               beq,
    input  logic               zero,
    input  logic               win_update,
    output logic [1:0]         win_ptr,
    output logic [ADDR_W-1:0]  pc
);

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [1:0]         win_ptr_q, win_ptr_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  npc;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc      (pc_q),
        .instr   (instr_q),
        .jump    (jump),
        .beq     (beq),
        .zero    (zero),
        .next_pc (npc)
    );

    // The request is registered so it first rises one edge after reset release.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        win_ptr_d = win_ptr_q;
        req_d     = req_q;
        case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                if (imem_ack && req_q) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                    req_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                req_d = 1'b0;
                if (exec_done) begin
                    pc_d    = npc;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    if (win_update) begin
                        win_ptr_d = win_ptr_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            win_ptr_q <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            win_ptr_q <= win_ptr_d;
            req_q     <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign instr_valid = (state_q == ST_ISSUE);
    assign win_ptr     = win_ptr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        jump;
    logic        beq;
    logic        zero;
    logic        win_update;
    logic [1:0]  win_ptr;
    logic [11:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .jump        (jump),
        .beq         (beq),
        .zero        (zero),
        .win_update  (win_update),
        .win_ptr     (win_ptr),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Deliver one instruction word, then complete it with the given feedback.
    task automatic run_instr(input logic [15:0] w, input logic j, input logic b,
                             input logic z, input logic wu);
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
        check("issue_valid", 32'(instr_valid), 1);
        exec_done  = 1'b1;
        jump       = j;
        beq        = b;
        zero       = z;
        win_update = wu;
        tick();
        exec_done  = 1'b0;
        jump       = 1'b0;
        beq        = 1'b0;
        zero       = 1'b0;
        win_update = 1'b0;
        $display("instr 0x%04h j=%0b b=%0b z=%0b wu=%0b -> addr 0x%03h win %0d",
                 w, j, b, z, wu, imem_addr, win_ptr);
    endtask

    int exp_win [4] = '{1, 2, 3, 0};

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        exec_done  = 1'b0;
        jump       = 1'b0;
        beq        = 1'b0;
        zero       = 1'b0;
        win_update = 1'b0;
        repeat (3) tick();
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_win", 32'(win_ptr), 0);

        rst_n = 1'b1;
        #1;
        check("req_before_edge", 32'(imem_req), 0);
        tick();
        check("first_req", 32'(imem_req), 1);
        check("first_addr", 32'(imem_addr), 0);
        check("first_valid", 32'(instr_valid), 0);
        tick();
        tick();
        check("addr_stable", 32'(imem_addr), 0);
        check("req_held", 32'(imem_req), 1);

        imem_ack   = 1'b1;
        imem_rdata = 16'h1000;
        tick();
        imem_ack   = 1'b0;
        check("ack_valid", 32'(instr_valid), 1);
        check("ack_instr", 32'(instr), 32'h1000);
        check("ack_opcode", 32'(opcode), 1);
        check("issue_req", 32'(imem_req), 0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("seq_req", 32'(imem_req), 1);
        check("seq_addr", 32'(imem_addr), 1);
        check("seq_valid", 32'(instr_valid), 0);
        $display("first instr 0x1000 -> addr 0x%03h", imem_addr);

        run_instr(16'h2005, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jump_to5", 32'(imem_addr), 5);

        exec_done = 1'b1;
        jump      = 1'b1;
        tick();
        exec_done = 1'b0;
        jump      = 1'b0;
        check("done_in_fetch_addr", 32'(imem_addr), 5);
        check("done_in_fetch_req", 32'(imem_req), 1);
        check("done_in_fetch_valid", 32'(instr_valid), 0);

        run_instr(16'h2123, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jump_123", 32'(imem_addr), 32'h123);

        run_instr(16'h200A, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jump_to10", 32'(imem_addr), 10);
        run_instr(16'h40FE, 1'b0, 1'b1, 1'b1, 1'b0);
        check("beq_taken", 32'(imem_addr), 9);

        run_instr(16'h200A, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr(16'h40FE, 1'b0, 1'b1, 1'b0, 1'b0);
        check("beq_not_taken", 32'(imem_addr), 11);

        run_instr(16'h2FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jump_fff", 32'(imem_addr), 32'hFFF);
        run_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pc_wrap", 32'(imem_addr), 0);

        run_instr(16'h2030, 1'b1, 1'b1, 1'b1, 1'b0);
        check("jump_priority", 32'(imem_addr), 32'h030);
        run_instr(16'h4080, 1'b0, 1'b1, 1'b1, 1'b0);
        check("beq_neg_wrap", 32'(imem_addr), 32'hFB1);

        imem_ack   = 1'b1;
        imem_rdata = 16'h3ABC;
        tick();
        imem_rdata = 16'h5555;
        jump       = 1'b1;
        beq        = 1'b1;
        zero       = 1'b1;
        win_update = 1'b1;
        tick();
        imem_ack   = 1'b0;
        jump       = 1'b0;
        beq        = 1'b0;
        zero       = 1'b0;
        win_update = 1'b0;
        check("ack_in_issue_instr", 32'(instr), 32'h3ABC);
        check("no_done_valid", 32'(instr_valid), 1);
        check("no_done_win", 32'(win_ptr), 0);
        check("no_done_pc", 32'(pc), 32'hFB1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("after_hold_addr", 32'(imem_addr), 32'hFB2);

        for (int i = 0; i < 4; i++) begin
            run_instr(16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
            check("win_step", 32'(win_ptr), 32'(exp_win[i]));
        end
        check("win_seq_addr", 32'(imem_addr), 32'hFB6);

        win_update = 1'b1;
        tick();
        win_update = 1'b0;
        check("win_no_done", 32'(win_ptr), 0);

        check("pre_reset_req", 32'(imem_req), 1);
        rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(imem_req), 0);
        check("async_pc", 32'(pc), 0);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        imem_ack   = 1'b0;
        check("rst_ack_instr", 32'(instr), 0);
        check("rst_ack_valid", 32'(instr_valid), 0);
        check("rst_ack_req", 32'(imem_req), 0);
        rst_n = 1'b1;
        tick();
        check("restart_req", 32'(imem_req), 1);
        check("restart_addr", 32'(imem_addr), 0);
        check("restart_win", 32'(win_ptr), 0);
        $display("reset mid-fetch -> restart addr 0x%03h", imem_addr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
